instr_fetch_buffer: RTL and testbench

- Sits between the instruction-fetch stage (PC generator) and the decoder.
- Each cycle it issues the current PC to the synchronous instruction ROM, which has 1-cycle read latency.
- It captures the returned instruction with its PC in a small FIFO and presents it to decode with a valid/ready handshake.
- It back-pressures the fetch stage with a stall and discards wrong-path instructions on a branch/jump flush.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/instr_fetch_buffer.sv | 105 ++++++++++
 tb/tb_instr_fetch_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
//   INSTR_W / ADDR_W : instruction word and PC widths
//   FETCH_DEPTH      : default number of buffered fetch entries
//   fetch_entry_t    : one buffered instruction together with its PC
package fetch_pkg;

   localparam int INSTR_W     = 9;
   localparam int ADDR_W      = 16;
   localparam int FETCH_DEPTH = 4;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch_entry_t with an explicit occupancy counter.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   push, wr_entry : write wr_entry at the write pointer
//   pop            : advance the read pointer (ignored while empty)
//   clear          : drop all contents, pointers back to 0 (beats push/pop)
//   rd_entry       : combinational read of the head entry
//   full, empty    : occupancy flags
//   count          : number of occupied entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  fetch_entry_t                wr_entry,
   input  logic                        pop,
   input  logic                        clear,
   output fetch_entry_t                rd_entry,
   output logic                        full,
   output logic                        empty,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("fetch_fifo: DEPTH must be a power of two and at least 2");
   end

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop & ~empty & ~clear;
   assign do_push  = push & ~clear;
   assign rd_entry = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) bits, so the +1 wraps modulo DEPTH;
   // the separate counter is what distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read out until it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   // A write into a full FIFO is only legal when the head leaves the same cycle.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between the PC generator and the decoder.
// Issues the PC to a 1-cycle-latency instruction ROM, captures the returned
// word with its PC in a FIFO and hands it to decode with valid/ready.
// Ports:
//   CLK, reset_ctrl_n      : clock, synchronous active-low reset
//   pc_in, pc_valid_in     : fetch request from the PC generator
//   fetch_stall_out        : fetch stage must hold its PC while high
//   imem_addr_out/rd_out   : ROM request (address is pc_in passed through)
//   imem_data_in           : ROM data, one cycle after imem_rd_out
//   flush_ctrl             : taken branch; kill buffered and in-flight work
//   instr_out/instr_pc_out : head instruction and its PC
//   instr_valid_out        : head is valid
//   decode_ready_in        : decoder takes the head this cycle
//   count_out              : FIFO occupancy
// Instruction/address widths come from fetch_pkg because the buffered
// entry type is defined there.
module instr_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                        CLK,
   input  logic                        reset_ctrl_n,
   input  logic [ADDR_W-1:0]           pc_in,
   input  logic                        pc_valid_in,
   output logic                        fetch_stall_out,
   output logic [ADDR_W-1:0]           imem_addr_out,
   output logic                        imem_rd_out,
   input  logic [INSTR_W-1:0]          imem_data_in,
   input  logic                        flush_ctrl,
   output logic [INSTR_W-1:0]          instr_out,
   output logic [ADDR_W-1:0]           instr_pc_out,
   output logic                        instr_valid_out,
   input  logic                        decode_ready_in,
   output logic [cnt_width(DEPTH)-1:0] count_out
);

   localparam int CNT_W = cnt_width(DEPTH);

   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;
   logic [CNT_W:0]    occupancy;
   logic              capture;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   fetch_entry_t      wr_entry;
   fetch_entry_t      head;

   // Reserve a slot for the request already at the ROM, so every issued
   // fetch is guaranteed room when its data returns.
   assign occupancy       = {1'b0, count_out} + {{CNT_W{1'b0}}, inflight};
   assign fetch_stall_out = (occupancy >= (CNT_W+1)'(DEPTH));

   assign imem_addr_out = pc_in;
   assign imem_rd_out   = pc_valid_in & ~fetch_stall_out & ~flush_ctrl;

   // The response landing in a flush cycle belongs to the wrong path.
   assign capture        = inflight & ~flush_ctrl;
   assign wr_entry.instr = imem_data_in;
   assign wr_entry.pc    = inflight_pc;

   assign instr_valid_out = ~fifo_empty;
   assign pop             = instr_valid_out & decode_ready_in & ~flush_ctrl;

   // Gate the head so an empty buffer shows zeros, not stale storage.
   assign instr_out    = instr_valid_out ? head.instr : '0;
   assign instr_pc_out = instr_valid_out ? head.pc    : '0;

   always_ff @(posedge CLK) begin
      if (!reset_ctrl_n) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else if (flush_ctrl) begin
         inflight    <= 1'b0;
      end else begin
         // Back-to-back issue keeps the flag set: one fetch per cycle.
         inflight <= imem_rd_out;
         if (imem_rd_out) inflight_pc <= pc_in;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (reset_ctrl_n),
      .push     (capture),
      .wr_entry (wr_entry),
      .pop      (pop),
      .clear    (flush_ctrl),
      .rd_entry (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (count_out)
   );

   // The stall reservation must keep buffered plus outstanding within DEPTH.
   a_occupancy: assert property (@(posedge CLK) disable iff (!reset_ctrl_n)
      occupancy <= (CNT_W+1)'(DEPTH));

   a_capture_room: assert property (@(posedge CLK) disable iff (!reset_ctrl_n)
      !(capture && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_fetch_buffer;
   import fetch_pkg::*;

   localparam int DEPTH = FETCH_DEPTH;

   logic                        CLK = 1'b0;
   logic                        reset_ctrl_n = 1'b0;
   logic [ADDR_W-1:0]           pc_in = '0;
   logic                        pc_valid_in = 1'b0;
   logic                        fetch_stall_out;
   logic [ADDR_W-1:0]           imem_addr_out;
   logic                        imem_rd_out;
   logic [INSTR_W-1:0]          imem_data_in = '0;
   logic                        flush_ctrl = 1'b0;
   logic [INSTR_W-1:0]          instr_out;
   logic [ADDR_W-1:0]           instr_pc_out;
   logic                        instr_valid_out;
   logic                        decode_ready_in = 1'b0;
   logic [cnt_width(DEPTH)-1:0] count_out;

   always #5 CLK = ~CLK;

   instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
      .CLK             (CLK),
      .reset_ctrl_n    (reset_ctrl_n),
      .pc_in           (pc_in),
      .pc_valid_in     (pc_valid_in),
      .fetch_stall_out (fetch_stall_out),
      .imem_addr_out   (imem_addr_out),
      .imem_rd_out     (imem_rd_out),
      .imem_data_in    (imem_data_in),
      .flush_ctrl      (flush_ctrl),
      .instr_out       (instr_out),
      .instr_pc_out    (instr_pc_out),
      .instr_valid_out (instr_valid_out),
      .decode_ready_in (decode_ready_in),
      .count_out       (count_out)
   );

   // ROM contents: addr+0x100 for small addresses, high bits folded in.
   function automatic logic [8:0] rom(input logic [15:0] a);
      return (a[8:0] ^ a[15:7]) + 9'h100;
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge CLK) begin
      if (imem_rd_out) imem_data_in <= rom(imem_addr_out);
   end

   // Reference model: in-order queue of delivered instructions plus at most
   // one outstanding ROM request.
   typedef struct {
      logic [8:0]  instr;
      logic [15:0] pc;
   } ent_t;

   ent_t        q[$];
   bit          pend = 0;
   logic [15:0] pend_pc = '0;
   bit          exp_rd = 0;
   logic [15:0] cur_pc = '0;
   logic [15:0] flush_target = '0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      bit          stall;
      bit          vld;
      logic [8:0]  ei;
      logic [15:0] ep;
      stall  = (q.size() + int'(pend)) >= DEPTH;
      exp_rd = pc_valid_in && !stall && !flush_ctrl;
      vld    = q.size() != 0;
      ei     = vld ? q[0].instr : 9'h0;
      ep     = vld ? q[0].pc : 16'h0;
      chk("stall", 32'(fetch_stall_out), 32'(stall));
      chk("imem_rd", 32'(imem_rd_out), 32'(exp_rd));
      chk("imem_addr", 32'(imem_addr_out), 32'(pc_in));
      chk("valid", 32'(instr_valid_out), 32'(vld));
      chk("instr", 32'(instr_out), 32'(ei));
      chk("instr_pc", 32'(instr_pc_out), 32'(ep));
      chk("count", 32'(count_out), 32'(q.size()));
   endtask

   task automatic model_step();
      ent_t e;
      if (!reset_ctrl_n) begin
         q.delete();
         pend = 0;
      end else if (flush_ctrl) begin
         q.delete();
         pend   = 0;
         cur_pc = flush_target;
      end else begin
         if (q.size() != 0 && decode_ready_in) void'(q.pop_front());
         if (pend) begin
            e.instr = rom(pend_pc);
            e.pc    = pend_pc;
            q.push_back(e);
         end
         pend    = exp_rd;
         pend_pc = pc_in;
         if (exp_rd) cur_pc = cur_pc + 16'd1;
      end
   endtask

   // One clock: drive on the falling edge, check, then advance the model.
   task automatic cyc(input bit rst_n, input bit pcv, input bit fl, input bit rdy);
      @(negedge CLK);
      reset_ctrl_n    = rst_n;
      pc_valid_in     = pcv;
      flush_ctrl      = fl;
      decode_ready_in = rdy;
      pc_in           = cur_pc;
      #1;
      compare_all();
      @(posedge CLK);
      model_step();
   endtask

   initial begin
      // Reset held for two cycles, then released idle.
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);

      // Streaming PCs 0..5 with the decoder always ready.
      cur_pc = 16'h0;
      repeat (6) cyc(1, 1, 0, 1);
      repeat (3) cyc(1, 0, 0, 1);

      // Back-pressure: decoder stalled until the buffer fills.
      cur_pc = 16'h10;
      repeat (6) cyc(1, 1, 0, 0);
      #1;
      chk("bp_count", 32'(count_out), 32'd4);
      chk("bp_head", 32'(instr_pc_out), 32'h10);
      chk("bp_stall", 32'(fetch_stall_out), 32'd1);
      repeat (6) cyc(1, 0, 0, 1);

      // Three buffered plus one in flight, then push/pop across the wrap.
      cur_pc = 16'h20;
      repeat (4) cyc(1, 1, 0, 0);
      repeat (10) cyc(1, 1, 0, 1);
      repeat (4) cyc(1, 0, 0, 1);

      // Flush with three buffered and one in flight; redirect to 0x40.
      cur_pc = 16'h30;
      repeat (4) cyc(1, 1, 0, 0);
      flush_target = 16'h40;
      cyc(1, 1, 1, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      #1;
      chk("flush_vld", 32'(instr_valid_out), 32'd1);
      chk("flush_pc", 32'(instr_pc_out), 32'h40);
      repeat (6) cyc(1, 0, 0, 1);

      // Reset while two entries are buffered and a flush is requested.
      cur_pc = 16'h50;
      repeat (2) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
      #1;
      chk("mrst_count", 32'(count_out), 32'd0);
      chk("mrst_valid", 32'(instr_valid_out), 32'd0);
      cyc(1, 0, 0, 0);

      // Random traffic with occasional flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) flush_target = 16'($urandom);
         cyc(($urandom_range(199) != 0), ($urandom_range(3) != 0),
             ($urandom_range(15) == 0), ($urandom_range(2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
